// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - VGA pixel-rate divider, h/v counters and sync/blanking/strobe decode (option: VGA_FRAME_COUNTER_EN)
module vga_sync_ctrl #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pixel_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    // Counter limits and decode boundaries, pre-sized to the 10-bit counter width.
    localparam logic [9:0] H_LAST     = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
    // Divider is 4 bits wide, enough for the full 1..16 divide range.
    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);

    logic [3:0] div_q,    div_d;
    logic       tick_q,   tick_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       hsync_q,  hsync_d;
    logic       vsync_q,  vsync_d;
    logic       von_q,    von_d;
    logic       lstart_q, lstart_d;
    logic       fstart_q, fstart_d;

    // Next-state: divider, counters, and decode of the next counter values so
    // that every registered output lines up with hcount/vcount.
    always_comb begin
        div_d    = div_q;
        tick_d   = 1'b0;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        lstart_d = 1'b0;
        fstart_d = 1'b0;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        von_d    = von_q;
        if (enable) begin
            if (div_q == DIV_LAST) begin
                div_d  = 4'd0;
                tick_d = 1'b1;
                if (hcount_q == H_LAST) begin
                    hcount_d = 10'd0;
                    lstart_d = 1'b1;
                    if (vcount_q == V_LAST) begin
                        vcount_d = 10'd0;
                        fstart_d = 1'b1;
                    end else begin
                        vcount_d = vcount_q + 10'd1;
                    end
                end else begin
                    hcount_d = hcount_q + 10'd1;
                end
            end else begin
                div_d = div_q + 4'd1;
            end
            // Decoded only while running, so a freeze holds the last levels.
            hsync_d = !((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST));
            vsync_d = !((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST));
            von_d   = (hcount_d < H_VIS) && (vcount_d < V_VIS);
        end
    end

    // State and output registers; reset takes effect immediately, mid-frame too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= 4'd0;
            tick_q   <= 1'b0;
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            von_q    <= 1'b0;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            von_q    <= von_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fcnt_q;

    // Frame counter steps on each frame wrap; the strobe is already gated by enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q <= 8'd0;
        end else if (fstart_d) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

    assign pixel_tick  = tick_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = von_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb/tb_vga_sync_ctrl.sv - self-checking bench for vga_sync_ctrl on a reduced raster
module tb_vga_sync_ctrl;

    // Reduced raster keeps whole frames short: 15 x 8 positions.
    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic       tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic von;
    } vec_t;

    localparam obs_t RST_OBS = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    logic       tick0, hs0, vs0, von0, ls0, fs0;
    logic [9:0] h0, v0;
    logic [7:0] fc0;
    logic       tick1, hs1, vs1, von1, ls1, fs1;
    logic [9:0] h1, v1;
    logic [7:0] fc1;

    obs_t act0, act1;
    assign act0 = {tick0, h0, v0, hs0, vs0, von0, ls0, fs0, fc0};
    assign act1 = {tick1, h1, v1, hs1, vs1, von1, ls1, fs1, fc1};

    int checks   = 0;
    int failures = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t m_o[2];
    int   m_div[2];
    int   m_pos[2];
    int   m_fc[2];

    always #5 clk = ~clk;

    vga_sync_ctrl #(
        .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2)
    ) dut0 (
        .clk(clk), .reset(rst), .enable(en), .pixel_tick(tick0),
        .hcount(h0), .vcount(v0), .hsync(hs0), .vsync(vs0), .video_on(von0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_sync_ctrl #(
        .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1)
    ) dut1 (
        .clk(clk), .reset(rst), .enable(en), .pixel_tick(tick1),
        .hcount(h1), .vcount(v1), .hsync(hs1), .vsync(vs1), .video_on(von1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position kept as a linear index within the frame.
    task automatic model_step(input int k);
        int d;
        int h;
        int v;
        d = (k == 0) ? 2 : 1;
        if (rst) begin
            m_div[k] = 0;
            m_pos[k] = 0;
            m_fc[k]  = 0;
            m_o[k]   = RST_OBS;
        end else if (en) begin
            m_o[k].tick = 1'b0;
            m_o[k].ls   = 1'b0;
            m_o[k].fs   = 1'b0;
            if (m_div[k] == d - 1) begin
                m_div[k]    = 0;
                m_o[k].tick = 1'b1;
                m_pos[k]    = (m_pos[k] + 1) % FT;
                if (m_pos[k] % HT == 0) m_o[k].ls = 1'b1;
                if (m_pos[k] == 0) begin
                    m_o[k].fs = 1'b1;
                    m_fc[k]   = (m_fc[k] + 1) % 256;
                end
            end else begin
                m_div[k] = m_div[k] + 1;
            end
            h = m_pos[k] % HT;
            v = m_pos[k] / HT;
            m_o[k].h   = 10'(h);
            m_o[k].v   = 10'(v);
            m_o[k].hs  = !(h >= HD + HF && h < HD + HF + HS);
            m_o[k].vs  = !(v >= VD + VF && v < VD + VF + VS);
            m_o[k].von = (h < HD) && (v < VD);
`ifdef VGA_FRAME_COUNTER_EN
            m_o[k].fc  = 8'(m_fc[k]);
`else
            m_o[k].fc  = 8'd0;
`endif
        end else begin
            m_o[k].tick = 1'b0;
            m_o[k].ls   = 1'b0;
            m_o[k].fs   = 1'b0;
        end
    endtask

    // Scoreboard producer: model advances on every active edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            q0.push_back(m_o[0]);
            q1.push_back(m_o[1]);
        end
    end

    // Scoreboard consumer: compare on the falling edge.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("sb_div2", 64'(act0), 64'(e));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sb_div1", 64'(act1), 64'(e));
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Clocks from reset release (at negedge+2) until dut0 ticks; checks latency and hcount.
    task automatic first_tick(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!tick0 && n < 10);
        chk({name, "_lat"}, 64'(n), 64'd2);
        chk({name, "_h"}, 64'(h0), 64'd1);
    endtask

    task automatic wait_pos(input int h, input int v, output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (n < 4 * FT && !ok) begin
            @(negedge clk);
            n++;
            if (h0 == 10'(h) && v0 == 10'(v)) ok = 1;
        end
    endtask

    vec_t vecs[13];

    initial begin
        bit ok;
        int n, nfs, nls, nhs, nls1, ntk1, nvon1, viol;

        vecs[0]  = '{h: 0,  v: 0, hs: 1'b1, vs: 1'b1, von: 1'b1};
        vecs[1]  = '{h: 7,  v: 0, hs: 1'b1, vs: 1'b1, von: 1'b1};
        vecs[2]  = '{h: 8,  v: 0, hs: 1'b1, vs: 1'b1, von: 1'b0};
        vecs[3]  = '{h: 9,  v: 1, hs: 1'b1, vs: 1'b1, von: 1'b0};
        vecs[4]  = '{h: 10, v: 1, hs: 1'b0, vs: 1'b1, von: 1'b0};
        vecs[5]  = '{h: 12, v: 2, hs: 1'b0, vs: 1'b1, von: 1'b0};
        vecs[6]  = '{h: 13, v: 2, hs: 1'b1, vs: 1'b1, von: 1'b0};
        vecs[7]  = '{h: 14, v: 3, hs: 1'b1, vs: 1'b1, von: 1'b0};
        vecs[8]  = '{h: 3,  v: 4, hs: 1'b1, vs: 1'b1, von: 1'b0};
        vecs[9]  = '{h: 0,  v: 5, hs: 1'b1, vs: 1'b0, von: 1'b0};
        vecs[10] = '{h: 12, v: 6, hs: 1'b0, vs: 1'b0, von: 1'b0};
        vecs[11] = '{h: 5,  v: 7, hs: 1'b1, vs: 1'b1, von: 1'b0};
        vecs[12] = '{h: 14, v: 7, hs: 1'b1, vs: 1'b1, von: 1'b0};

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        first_tick("boot_tick");

        // Decode table walked in raster order.
        for (int i = 0; i < 13; i++) begin
            wait_pos(vecs[i].h, vecs[i].v, ok);
            chk($sformatf("vec%0d_reached", i), 64'(ok), 64'd1);
            chk($sformatf("vec%0d_decode", i), 64'({hs0, vs0, von0}),
                64'({vecs[i].hs, vecs[i].vs, vecs[i].von}));
        end

        // One full frame of dut0 (= two of dut1): strobe and sync-width counts.
        nfs = 0; nls = 0; nhs = 0; nls1 = 0; ntk1 = 0; nvon1 = 0;
        for (int c = 0; c < 2 * FT; c++) begin
            @(negedge clk);
            if (fs0) begin
                nfs++;
                chk("fs_with_ls", 64'({ls0, h0, v0}), 64'({1'b1, 10'd0, 10'd0}));
            end
            if (ls0)   nls++;
            if (!hs0)  nhs++;
            if (ls1)   nls1++;
            if (tick1) ntk1++;
            if (von1)  nvon1++;
        end
        chk("frame_fs_count", 64'(nfs), 64'd1);
        chk("frame_ls_count", 64'(nls), 64'(VT));
        chk("hsync_low_clks", 64'(nhs), 64'(HS * 2 * VT));
        chk("div1_ls_count", 64'(nls1), 64'(2 * VT));
        chk("div1_tick_count", 64'(ntk1), 64'(2 * FT));
        chk("div1_von_clks", 64'(nvon1), 64'(2 * HD * VD));

        // Freeze on the last visible pixel, then resume.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(h0 == 10'(HD - 1) && tick0) && n < 4 * FT);
        chk("freeze_reached", 64'(h0), 64'(HD - 1));
        en = 1'b0;
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (h0 != 10'(HD - 1) || tick0 || ls0 || fs0 || tick1 || ls1 || fs1) viol++;
        end
        chk("freeze_violations", 64'(viol), 64'd0);
        chk("freeze_von_held", 64'(von0), 64'd1);
        en = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (h0 != 10'(HD) && n < 10);
        chk("resume_lat", 64'(n), 64'd2);
        chk("resume_von", 64'({tick0, von0}), 64'({1'b1, 1'b0}));

        // Asynchronous reset mid-line.
        wait_pos(5, 2, ok);
        chk("midline_reached", 64'(ok), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_div2", 64'(act0), 64'(RST_OBS));
        chk("async_rst_div1", 64'(act1), 64'(RST_OBS));
        @(negedge clk);
        #2 rst = 1'b0;
        first_tick("rst_tick");

`ifdef VGA_FRAME_COUNTER_EN
        nfs = 0;
        n = 0;
        while (nfs < 257 && n < 257 * 2 * FT + 500) begin
            @(negedge clk);
            n++;
            if (fs0) nfs++;
        end
        chk("fc_frames_seen", 64'(nfs), 64'd257);
        chk("fc_after_wrap", 64'(fc0), 64'd1);
`else
        chk("fc_tied_div2", 64'(fc0), 64'd0);
        chk("fc_tied_div1", 64'(fc1), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
